alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle controller that sequences the 16-bit datapath (register file, A/B/C pipeline registers, shifter, ALU, status register) for one instruction at a time. It latches a 16-bit instruction on a start handshake, decodes it, and drives register-select, load strobes, ALU op and write-back controls cycle by cycle. It sits between instruction fetch logic and the datapath. It reports ready via w.

Parameters:
ENABLE_HALT, 1, 1 = opcode 3'b111 enters HALT state; 0 = treated as illegal
ILLEGAL_TRAP, 0, 1 = illegal encoding enters HALT; 0 = pulse illegal and return to WAIT

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
s  input  1  start; sampled only while w=1
instr  input  16  instruction; sampled when s=1 and w=1
w  output  1  ready/idle (state WAIT)
reg_num  output  3  register-file read/write index
vsel  output  2  write-back source: 00 = C register, 01 = sximm8, 10/11 unused (driven 00)
write  output  1  register-file write enable
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status register
asel  output  1  1 = force ALU A input to zero
bsel  output  1  reserved; always 0
alu_op  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 NOT B
shift  output  2  shifter control for B path
sximm8  output  16  sign-extended ir[7:0]
halted  output  1  high in HALT
illegal  output  1  one-cycle pulse on illegal decode

Behaviour:
- Internal ir[15:0]; fields: opcode=ir[15:13], op=ir[12:11], Rn=ir[10:8], Rd=ir[7:5], sh=ir[4:3], Rm=ir[2:0], imm8=ir[7:0].
- Legal: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN Rd,Rm{,sh}; 111/xx HALT (if ENABLE_HALT). All other encodings are illegal.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM, HALT.
- Outputs are Moore decode of state plus ir. Every output not listed for a state is 0. alu_op and shift are driven 00 outside EXEC/GET_B.
- WAIT: w=1. If s=1, ir<=instr and go to DECODE. Otherwise stay.
- DECODE: MOV imm -> WR_IMM; MOV reg, MVN -> GET_B; ADD/CMP/AND -> GET_A; HALT -> HALT; illegal -> illegal=1, then WAIT (or HALT if ILLEGAL_TRAP).
- GET_A: reg_num=Rn, loada=1 -> GET_B.
- GET_B: reg_num=Rm, loadb=1, shift=sh -> EXEC.
- EXEC: loadc=1, shift=sh. alu_op=op for opcode 101; alu_op=00 with asel=1 for MOV reg. CMP: loadc=0, loads=1, alu_op=01, next state WAIT. All others -> WR_REG.
- WR_REG: reg_num=Rd, vsel=00, write=1 -> WAIT.
- WR_IMM: reg_num=Rn, vsel=01, write=1 -> WAIT.
- HALT: w=0, halted=1. Stays until reset; s is ignored.
- sximm8 = {{8{ir[7]}}, ir[7:0]}, driven continuously from ir.
- Latency from the s-sampling edge to w=1, counted in rising edges: ADD/AND = 5, CMP = 4, MOV reg/MVN = 4, MOV imm = 2, illegal = 1.
- s is ignored outside WAIT, and ir does not change outside WAIT.
- Reset (asynchronous, mid-instruction included): state=WAIT, ir=0, all strobes 0, w=1, halted=0, illegal=0, sximm8=0. No partial write completes after reset.
- Back-to-back: s held high in WAIT starts the next instruction on the same edge that WAIT is first sampled.

Test Plan:
- Reset then s=1, instr=16'hD207 (MOV R2,#7): DECODE, then WR_IMM with reg_num=2, vsel=01, sximm8=16'h0007, write=1; w=1 two edges after start.
- MOV R1,#-1 (16'hD1FF): sximm8=16'hFFFF, reg_num=1.
- ADD R3,R1,R2 (16'hA162): GET_A (reg_num=1, loada), GET_B (reg_num=2, loadb, shift=00), EXEC (alu_op=00, loadc), WR_REG (reg_num=3, write); w back at edge 5.
- CMP R1,R2 (16'hA902): EXEC has loads=1, loadc=0, alu_op=01; no write at any point; w at edge 4.
- MOV R4,R5,LSL#1 (16'hC08D): no GET_A; EXEC asel=1, alu_op=00, shift=01; WR_REG reg_num=4.
- Illegal 16'h0000: illegal is a 1-cycle pulse, no strobes. HALT 16'hE000: halted=1, w=0, s ignored for 10 cycles. Deassert rst_n mid-ADD in GET_B: immediately w=1 and all strobes 0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and control bundle between instruction fetch, the sequencer and the datapath.
// The master side is fetch logic and the datapath; the slave side is the sequencer.
interface alu_seq_if;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic [2:0]  reg_num;
    logic [1:0]  vsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic        halted;
    logic        illegal;

    modport master (
        output s, instr,
        input  w, reg_num, vsel, write, loada, loadb, loadc, loads,
               asel, bsel, alu_op, shift, sximm8, halted, illegal
    );

    modport slave (
        input  s, instr,
        output w, reg_num, vsel, write, loada, loadb, loadc, loads,
               asel, bsel, alu_op, shift, sximm8, halted, illegal
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit datapath: latches one instruction on the start
// handshake and walks it through operand fetch, execute and write-back.
module alu_seq_ctrl #(
    parameter bit ENABLE_HALT  = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_GET_A  = 3'd2,
        ST_GET_B  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WR_REG = 3'd5,
        ST_WR_IMM = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_MOV_IMM = 3'd1,
        CL_MOV_REG = 3'd2,
        CL_ALU     = 3'd3,
        CL_CMP     = 3'd4,
        CL_MVN     = 3'd5,
        CL_HALT    = 3'd6
    } iclass_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] ir_r;
    logic        ir_load_s;
    iclass_t     iclass_s;

    logic [2:0] opcode_s;
    logic [1:0] op_s;
    logic [2:0] rn_s;
    logic [2:0] rd_s;
    logic [1:0] sh_s;
    logic [2:0] rm_s;

    logic       w_s;
    logic [2:0] reg_num_s;
    logic [1:0] vsel_s;
    logic       write_s;
    logic       loada_s;
    logic       loadb_s;
    logic       loadc_s;
    logic       loads_s;
    logic       asel_s;
    logic [1:0] alu_op_s;
    logic [1:0] shift_s;
    logic       halted_s;
    logic       illegal_s;

    assign opcode_s = ir_r[15:13];
    assign op_s     = ir_r[12:11];
    assign rn_s     = ir_r[10:8];
    assign rd_s     = ir_r[7:5];
    assign sh_s     = ir_r[4:3];
    assign rm_s     = ir_r[2:0];

    // Sort an encoding into the instruction class that selects its state path.
    function automatic iclass_t classify(input logic [2:0] opc, input logic [1:0] opf);
        iclass_t cl;
        cl = CL_ILLEGAL;
        case (opc)
            3'b110: begin
                case (opf)
                    2'b10:   cl = CL_MOV_IMM;
                    2'b00:   cl = CL_MOV_REG;
                    default: cl = CL_ILLEGAL;
                endcase
            end
            3'b101: begin
                case (opf)
                    2'b01:   cl = CL_CMP;
                    2'b11:   cl = CL_MVN;
                    default: cl = CL_ALU;
                endcase
            end
            3'b111:  cl = ENABLE_HALT ? CL_HALT : CL_ILLEGAL;
            default: cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

    assign iclass_s = classify(opcode_s, op_s);

    // State and instruction register; ir only moves while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT;
            ir_r    <= 16'h0000;
        end else begin
            state_r <= state_s;
            if (ir_load_s) begin
                ir_r <= bus.instr;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-state and Moore output decode from state and ir.
    always_comb begin
        state_s   = state_r;
        ir_load_s = 1'b0;
        w_s       = 1'b0;
        reg_num_s = 3'd0;
        vsel_s    = 2'b00;
        write_s   = 1'b0;
        loada_s   = 1'b0;
        loadb_s   = 1'b0;
        loadc_s   = 1'b0;
        loads_s   = 1'b0;
        asel_s    = 1'b0;
        alu_op_s  = 2'b00;
        shift_s   = 2'b00;
        halted_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                w_s = 1'b1;
                if (bus.s) begin
                    ir_load_s = 1'b1;
                    state_s   = ST_DECODE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case (iclass_s)
                    CL_MOV_IMM:         state_s = ST_WR_IMM;
                    CL_MOV_REG, CL_MVN: state_s = ST_GET_B;
                    CL_ALU, CL_CMP:     state_s = ST_GET_A;
                    CL_HALT:            state_s = ST_HALT;
                    default: begin
                        illegal_s = 1'b1;
                        state_s   = ILLEGAL_TRAP ? ST_HALT : ST_WAIT;
                    end
                endcase
            end
            ST_GET_A: begin
                reg_num_s = rn_s;
                loada_s   = 1'b1;
                state_s   = ST_GET_B;
            end
            ST_GET_B: begin
                reg_num_s = rm_s;
                loadb_s   = 1'b1;
                shift_s   = sh_s;
                state_s   = ST_EXEC;
            end
            ST_EXEC: begin
                shift_s = sh_s;
                // MOV reg goes through the ALU as 0 + B; CMP only updates status.
                if (iclass_s == CL_MOV_REG) begin
                    asel_s   = 1'b1;
                    alu_op_s = 2'b00;
                    loadc_s  = 1'b1;
                    state_s  = ST_WR_REG;
                end else if (iclass_s == CL_CMP) begin
                    loads_s  = 1'b1;
                    alu_op_s = 2'b01;
                    state_s  = ST_WAIT;
                end else begin
                    alu_op_s = op_s;
                    loadc_s  = 1'b1;
                    state_s  = ST_WR_REG;
                end
            end
            ST_WR_REG: begin
                reg_num_s = rd_s;
                vsel_s    = 2'b00;
                write_s   = 1'b1;
                state_s   = ST_WAIT;
            end
            ST_WR_IMM: begin
                reg_num_s = rn_s;
                vsel_s    = 2'b01;
                write_s   = 1'b1;
                state_s   = ST_WAIT;
            end
            ST_HALT: begin
                halted_s = 1'b1;
                state_s  = ST_HALT;
            end
            default: begin
                state_s = ST_WAIT;
            end
        endcase
    end

    assign bus.w       = w_s;
    assign bus.reg_num = reg_num_s;
    assign bus.vsel    = vsel_s;
    assign bus.write   = write_s;
    assign bus.loada   = loada_s;
    assign bus.loadb   = loadb_s;
    assign bus.loadc   = loadc_s;
    assign bus.loads   = loads_s;
    assign bus.asel    = asel_s;
    assign bus.bsel    = 1'b0;
    assign bus.alu_op  = alu_op_s;
    assign bus.shift   = shift_s;
    assign bus.halted  = halted_s;
    assign bus.illegal = illegal_s;
    assign bus.sximm8  = {{8{ir_r[7]}}, ir_r[7:0]};

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed latency table, randomized traces against
// a per-instruction micro-step model, and hand sequences for back-to-back, reset and HALT.
module tb_alu_seq_ctrl;

    logic clk;
    logic rst_n;

    alu_seq_if bus ();

    alu_seq_ctrl #(.ENABLE_HALT(1'b1), .ILLEGAL_TRAP(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] reg_num;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] alu_op;
        logic [1:0] shift;
        logic       halted;
        logic       illegal;
    } out_t;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [15:0] simm;
        int          writes;
        int          loads_n;
        int          ill;
    } vec_t;

    int   checks;
    int   errors;
    out_t exp_q[$];
    out_t idle_rec;
    out_t halt_rec;

    function automatic out_t sample();
        out_t o;
        o.w       = bus.w;
        o.reg_num = bus.reg_num;
        o.vsel    = bus.vsel;
        o.write   = bus.write;
        o.loada   = bus.loada;
        o.loadb   = bus.loadb;
        o.loadc   = bus.loadc;
        o.loads   = bus.loads;
        o.asel    = bus.asel;
        o.bsel    = bus.bsel;
        o.alu_op  = bus.alu_op;
        o.shift   = bus.shift;
        o.halted  = bus.halted;
        o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list of per-cycle outputs from DECODE until idle again.
    task automatic model(input logic [15:0] ins);
        out_t c;
        logic [2:0] opc;
        logic [1:0] op;
        opc = ins[15:13];
        op  = ins[12:11];
        exp_q.delete();
        c = '0;
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(c);
            c = '0; c.reg_num = ins[10:8]; c.vsel = 2'b01; c.write = 1'b1;
            exp_q.push_back(c);
        end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
            exp_q.push_back(c);
            if (opc == 3'b101 && op != 2'b11) begin
                c = '0; c.reg_num = ins[10:8]; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = '0; c.reg_num = ins[2:0]; c.loadb = 1'b1; c.shift = ins[4:3];
            exp_q.push_back(c);
            c = '0; c.shift = ins[4:3];
            if (opc == 3'b110) begin
                c.asel = 1'b1; c.loadc = 1'b1; c.alu_op = 2'b00;
            end else if (op == 2'b01) begin
                c.loads = 1'b1; c.alu_op = 2'b01;
            end else begin
                c.loadc = 1'b1; c.alu_op = op;
            end
            exp_q.push_back(c);
            if (!(opc == 3'b101 && op == 2'b01)) begin
                c = '0; c.reg_num = ins[7:5]; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end else begin
            c.illegal = 1'b1;
            exp_q.push_back(c);
        end
        exp_q.push_back(idle_rec);
    endtask

    // Issue one instruction; leaves the bench at the negedge after the sampling edge.
    task automatic issue(input logic [15:0] ins);
        @(negedge clk);
        bus.s     = 1'b1;
        bus.instr = ins;
        @(posedge clk);
        @(negedge clk);
        bus.s = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n, wr, ld, il;
        n = 0; wr = 0; ld = 0; il = 0;
        issue(v.instr);
        chk($sformatf("sximm8 %h", v.instr), {48'd0, bus.sximm8}, {48'd0, v.simm});
        while (bus.w !== 1'b1 && n < 20) begin
            wr += int'(bus.write);
            ld += int'(bus.loads);
            il += int'(bus.illegal);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency %h", v.instr), 64'(n), 64'(v.lat));
        chk($sformatf("writes %h", v.instr), 64'(wr), 64'(v.writes));
        chk($sformatf("loads %h", v.instr), 64'(ld), 64'(v.loads_n));
        chk($sformatf("illegal %h", v.instr), 64'(il), 64'(v.ill));
    endtask

    task automatic run_model(input logic [15:0] ins);
        model(ins);
        issue(ins);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("trace %h step %0d", ins, k), 64'(sample()), 64'(exp_q[k]));
            chk($sformatf("trace sximm8 %h", ins), {48'd0, bus.sximm8},
                {48'd0, {{8{ins[7]}}, ins[7:0]}});
            if (k < exp_q.size() - 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [15:0] ins;
        logic [2:0]  opc;
        checks = 0;
        errors = 0;
        idle_rec = '0; idle_rec.w = 1'b1;
        halt_rec = '0; halt_rec.halted = 1'b1;

        vecs[0] = '{16'hD207, 2, 16'h0007, 1, 0, 0};
        vecs[1] = '{16'hD1FF, 2, 16'hFFFF, 1, 0, 0};
        vecs[2] = '{16'hA162, 5, 16'h0062, 1, 0, 0};
        vecs[3] = '{16'hA902, 4, 16'h0002, 0, 1, 0};
        vecs[4] = '{16'hC08D, 4, 16'hFF8D, 1, 0, 0};
        vecs[5] = '{16'hB0A1, 5, 16'hFFA1, 1, 0, 0};
        vecs[6] = '{16'hB8E3, 4, 16'hFFE3, 1, 0, 0};
        vecs[7] = '{16'h0000, 1, 16'h0000, 0, 0, 1};
        vecs[8] = '{16'hC800, 1, 16'h0000, 0, 0, 1};
        vecs[9] = '{16'hD800, 1, 16'h0000, 0, 0, 1};

        rst_n     = 1'b0;
        bus.s     = 1'b0;
        bus.instr = 16'h0000;
        @(negedge clk);
        chk("reset outputs", 64'(sample()), 64'(idle_rec));
        chk("reset sximm8", {48'd0, bus.sximm8}, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        run_model(16'hD207);
        run_model(16'hA162);
        run_model(16'hA902);
        run_model(16'hC08D);

        for (int r = 0; r < 60; r++) begin
            ins = 16'($urandom());
            case ($urandom_range(0, 3))
                0:       opc = 3'b101;
                1:       opc = 3'b110;
                2:       opc = 3'b101;
                default: opc = 3'($urandom_range(0, 6));
            endcase
            ins[15:13] = opc;
            run_model(ins);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Back-to-back with s held high; ir must ignore instr changes mid-flight.
        @(negedge clk);
        bus.s = 1'b1; bus.instr = 16'hD207;
        @(posedge clk); @(negedge clk);
        bus.instr = 16'hD1FF;
        @(posedge clk); @(negedge clk);
        chk("b2b hold ir", {48'd0, bus.sximm8}, 64'h0007);
        chk("b2b wr_imm reg", 64'(bus.reg_num), 64'd2);
        @(posedge clk); @(negedge clk);
        chk("b2b idle w", 64'(bus.w), 64'd1);
        @(posedge clk); @(negedge clk);
        bus.s = 1'b0;
        chk("b2b restart w", 64'(bus.w), 64'd0);
        chk("b2b new ir", {48'd0, bus.sximm8}, 64'hFFFF);
        @(posedge clk); @(negedge clk);
        chk("b2b second write reg", 64'(bus.reg_num), 64'd1);
        chk("b2b second write", 64'(bus.write), 64'd1);
        @(posedge clk); @(negedge clk);

        // Asynchronous reset in the middle of an ADD.
        issue(16'hA162);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("midreset in get_b", 64'(bus.loadb), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", 64'(sample()), 64'(idle_rec));
        chk("midreset sximm8", {48'd0, bus.sximm8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk("post reset idle", 64'(sample()), 64'(idle_rec));
        end

        // HALT is sticky and ignores s until reset.
        issue(16'hE000);
        @(posedge clk); @(negedge clk);
        chk("halt outputs", 64'(sample()), 64'(halt_rec));
        bus.s = 1'b1; bus.instr = 16'hD207;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            chk("halt sticky", 64'(sample()), 64'(halt_rec));
        end
        bus.s = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt reset", 64'(sample()), 64'(idle_rec));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
